// File: rtl/branch_target_buffer.sv
// N-way set-associative branch target buffer with tree pseudo-LRU replacement and a sequential flush engine.
// Optional macro BTB_CONF_EN adds a 2-bit confidence counter per entry that gates hits and allocation.
module branch_target_buffer #(
  parameter int unsigned SETS  = 64,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned TAG_W = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic [1:0]  update_type,
  input  logic        update_taken,
  input  logic        flush,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [31:0] resp_target,
  output logic [1:0]  resp_type,
  output logic [1:0]  resp_way,
  output logic        busy
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned UPPER  = 30 - IDX_W;
  localparam int unsigned PW     = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int unsigned WAY_IW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_e;

  // Folds pc[31:IDX_W+2] into TAG_W bits; bit i of the upper field lands in tag bit i mod TAG_W.
  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
    logic [TAG_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < UPPER; i++) begin
      t[i % TAG_W] = t[i % TAG_W] ^ pc[IDX_W + 2 + i];
    end
    return t;
  endfunction

  // Bits are widened to a 3-bit scratch vector so every WAYS setting shares one body.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p, input logic [1:0] w);
    logic [2:0] e;
    e         = '0;
    e[PW-1:0] = p;
    if (WAYS == 2) begin
      e[0] = ~w[0];
    end else if (WAYS == 4) begin
      e[0] = ~w[1];
      if (w[1]) e[2] = ~w[0];
      else      e[1] = ~w[0];
    end
    return e[PW-1:0];
  endfunction

  function automatic logic [1:0] plru_victim(input logic [PW-1:0] p);
    logic [2:0] e;
    logic [1:0] v;
    e         = '0;
    e[PW-1:0] = p;
    v         = '0;
    if (WAYS == 2)      v = {1'b0, e[0]};
    else if (WAYS == 4) v = e[0] ? {1'b1, e[2]} : {1'b0, e[1]};
    return v;
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;

  logic [WAYS-1:0]    valid_q  [SETS];
  logic [PW-1:0]      plru_q   [SETS];
  logic [TAG_W-1:0]   tag_q    [SETS][WAYS];
  logic [31:0]        target_q [SETS][WAYS];
  logic [1:0]         type_q   [SETS][WAYS];
`ifdef BTB_CONF_EN
  logic [1:0]         conf_q   [SETS][WAYS];
  logic [1:0]         u_conf;
  logic [1:0]         u_conf_old;
`endif

  logic               resp_valid_q;
  logic               resp_hit_q;
  logic [31:0]        resp_target_q;
  logic [1:0]         resp_type_q;
  logic [1:0]         resp_way_q;

  logic [IDX_W-1:0]   l_idx;
  logic [TAG_W-1:0]   l_tag;
  logic               l_hit;
  logic [1:0]         l_way;
  logic [31:0]        l_target;
  logic [1:0]         l_type;

  logic [IDX_W-1:0]   u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_act;
  logic               u_match;
  logic [1:0]         u_match_way;
  logic               u_free;
  logic [1:0]         u_free_way;
  logic [1:0]         u_way;
  logic [WAY_IW-1:0]  u_wsel;
  logic               u_write;
  logic               u_wr_data;

  logic               unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0], update_taken};

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = tag_of(lookup_pc);
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = tag_of(update_pc);

  // Lookup: lowest matching way wins; no hits while the flush engine runs.
  always_comb begin
    logic cok;
    l_hit = 1'b0;
    l_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
`ifdef BTB_CONF_EN
      cok = conf_q[l_idx][w][1];
`else
      cok = 1'b1;
`endif
      if (!l_hit && valid_q[l_idx][w] && cok && (tag_q[l_idx][w] == l_tag)) begin
        l_hit = 1'b1;
        l_way = 2'(w);
      end
    end
    if (state_q != ST_IDLE) l_hit = 1'b0;
    l_target = l_hit ? target_q[l_idx][l_way[WAY_IW-1:0]] : lookup_pc + 32'd4;
    l_type   = l_hit ? type_q[l_idx][l_way[WAY_IW-1:0]] : 2'b00;
    if (!l_hit) l_way = '0;
  end

  // Update way choice: existing tag, then lowest invalid way, then PLRU victim.
  always_comb begin
    u_act       = update_en && (state_q == ST_IDLE) && !flush;
    u_match     = 1'b0;
    u_match_way = '0;
    u_free      = 1'b0;
    u_free_way  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!u_match && valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_match     = 1'b1;
        u_match_way = 2'(w);
      end
      if (!u_free && !valid_q[u_idx][w]) begin
        u_free     = 1'b1;
        u_free_way = 2'(w);
      end
    end
    if (u_match)     u_way = u_match_way;
    else if (u_free) u_way = u_free_way;
    else             u_way = plru_victim(plru_q[u_idx]);
    u_wsel = u_way[WAY_IW-1:0];
`ifdef BTB_CONF_EN
    u_write    = u_act && (u_match || update_taken);
    u_wr_data  = u_write && update_taken;
    u_conf_old = conf_q[u_idx][u_wsel];
    if (u_match) begin
      if (update_taken) u_conf = (u_conf_old == 2'd3) ? 2'd3 : u_conf_old + 2'd1;
      else              u_conf = (u_conf_old == 2'd0) ? 2'd0 : u_conf_old - 2'd1;
    end else begin
      u_conf = update_taken ? 2'd2 : 2'd1;
    end
`else
    u_write   = u_act;
    u_wr_data = u_act;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (flush)                              cnt_d   = '0;
        else if (cnt_q == IDX_W'(SETS - 1))     state_d = ST_IDLE;
        else                                    cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_FLUSH);
  end

  // Update touch is issued after the lookup touch so it wins on a shared set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_target_q <= '0;
      resp_type_q   <= '0;
      resp_way_q    <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= lookup_valid;
      if (lookup_valid) begin
        resp_hit_q    <= l_hit;
        resp_target_q <= l_target;
        resp_type_q   <= l_type;
        resp_way_q    <= l_way;
      end
      if (state_q == ST_FLUSH) begin
        valid_q[cnt_q] <= '0;
        plru_q[cnt_q]  <= '0;
      end else begin
        if (lookup_valid && l_hit) plru_q[l_idx] <= plru_touch(plru_q[l_idx], l_way);
        if (u_write) begin
          valid_q[u_idx][u_wsel] <= 1'b1;
          plru_q[u_idx]          <= plru_touch(plru_q[u_idx], u_way);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (u_write) begin
      tag_q[u_idx][u_wsel] <= u_tag;
`ifdef BTB_CONF_EN
      conf_q[u_idx][u_wsel] <= u_conf;
`endif
      if (u_wr_data) begin
        target_q[u_idx][u_wsel] <= update_target;
        type_q[u_idx][u_wsel]   <= update_type;
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_target = resp_target_q;
  assign resp_type   = resp_type_q;
  assign resp_way    = resp_way_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer (SETS=64, WAYS=2, TAG_W=10); BTB_CONF_EN selects the confidence scenario.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic [1:0]  update_type;
  logic        update_taken;
  logic        flush;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] resp_target;
  logic [1:0]  resp_type;
  logic [1:0]  resp_way;
  logic        busy;

  always #5 clk = ~clk;

  branch_target_buffer #(.SETS(64), .WAYS(2), .TAG_W(10)) dut (
    .clk(clk), .resetn(resetn),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
    .update_type(update_type), .update_taken(update_taken), .flush(flush),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_target(resp_target),
    .resp_type(resp_type), .resp_way(resp_way), .busy(busy)
  );

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic [31:0] tgt;
    logic [1:0]  typ;
    logic [1:0]  way;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && resp_valid) begin
      if (sb.size() == 0) begin
        check_eq("resp_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq($sformatf("hit@%0h", e.pc),    64'(resp_hit),    64'(e.hit));
        check_eq($sformatf("target@%0h", e.pc), 64'(resp_target), 64'(e.tgt));
        check_eq($sformatf("type@%0h", e.pc),   64'(resp_type),   64'(e.typ));
        check_eq($sformatf("way@%0h", e.pc),    64'(resp_way),    64'(e.way));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic hit, input logic [31:0] tgt,
                          input logic [1:0] typ, input logic [1:0] way);
    exp_t e;
    e.pc  = pc;
    e.hit = hit;
    e.tgt = hit ? tgt : pc + 32'd4;
    e.typ = hit ? typ : 2'b00;
    e.way = hit ? way : 2'd0;
    sb.push_back(e);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic hit, input logic [31:0] tgt,
                        input logic [1:0] typ, input logic [1:0] way);
    push_exp(pc, hit, tgt, typ, way);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    step();
    lookup_valid = 1'b0;
  endtask

  task automatic lookup_miss(input logic [31:0] pc);
    lookup(pc, 1'b0, 32'd0, 2'd0, 2'd0);
  endtask

  task automatic drive_update(input logic [31:0] pc, input logic [31:0] tgt,
                              input logic [1:0] typ, input logic taken);
    update_en     = 1'b1;
    update_pc     = pc;
    update_target = tgt;
    update_type   = typ;
    update_taken  = taken;
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [1:0] typ, input logic taken);
    drive_update(pc, tgt, typ, taken);
    step();
    update_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    check_eq(tag, 64'(busy), 64'd0);
  endtask

  task automatic drain();
    step();
    step();
    check_eq("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cycles;
    resetn = 1'b0; lookup_valid = 1'b0; lookup_pc = '0; update_en = 1'b0;
    update_pc = '0; update_target = '0; update_type = '0; update_taken = 1'b0; flush = 1'b0;
    step();
    step();
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_resp_hit", 64'(resp_hit), 64'd0);
    check_eq("rst_resp_target", 64'(resp_target), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    step();

    // Cold miss, then allocate and hit.
    lookup_miss(32'h0000_1000);
    update(32'h1000, 32'h8000, 2'b01, 1'b1);
    lookup(32'h1000, 1'b1, 32'h8000, 2'b01, 2'd0);

    // Fill set 0, refresh 0x1000, third tag evicts 0x2000.
    update(32'h1000, 32'hA000, 2'b00, 1'b1);
    update(32'h2000, 32'hB000, 2'b11, 1'b1);
    lookup(32'h2000, 1'b1, 32'hB000, 2'b11, 2'd1);
    lookup(32'h1000, 1'b1, 32'hA000, 2'b00, 2'd0);
    update(32'h3000, 32'hC000, 2'b01, 1'b1);
    lookup_miss(32'h2000);
    lookup(32'h1000, 1'b1, 32'hA000, 2'b00, 2'd0);
    lookup(32'h3000, 1'b1, 32'hC000, 2'b01, 2'd1);

    // Same-cycle update and lookup: read-before-write; victim is way 0 (0x1000).
    push_exp(32'h4000, 1'b0, 32'd0, 2'd0, 2'd0);
    lookup_valid = 1'b1; lookup_pc = 32'h4000;
    drive_update(32'h4000, 32'hD000, 2'b10, 1'b1);
    step();
    lookup_valid = 1'b0; update_en = 1'b0;
    lookup(32'h4000, 1'b1, 32'hD000, 2'b10, 2'd0);
    lookup_miss(32'h1000);
    update(32'h4000, 32'hE000, 2'b10, 1'b1);
    lookup(32'h4000, 1'b1, 32'hE000, 2'b10, 2'd0);
    lookup(32'h3000, 1'b1, 32'hC000, 2'b01, 2'd1);
    drain();

    // Flush walk: busy for exactly SETS cycles, mid-flush update dropped, lookup misses.
    flush = 1'b1;
    step();
    flush = 1'b0;
    cycles = 0;
    while (busy && cycles < 300) begin
      if (cycles == 5) drive_update(32'h5000, 32'h5555, 2'b00, 1'b1);
      if (cycles == 6) begin
        update_en = 1'b0;
        push_exp(32'h4000, 1'b0, 32'd0, 2'd0, 2'd0);
        lookup_valid = 1'b1; lookup_pc = 32'h4000;
      end
      if (cycles == 7) lookup_valid = 1'b0;
      step();
      cycles++;
    end
    check_eq("flush_busy_cycles", 64'(cycles), 64'd64);
    lookup_miss(32'h1000);
    lookup_miss(32'h5000);
    lookup_miss(32'h4000);
    lookup_miss(32'h3000);

    // Flush in the same cycle as an update drops the update.
    drive_update(32'h7000, 32'h7777, 2'b01, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0; update_en = 1'b0;
    wait_idle("flush2_timeout");
    lookup_miss(32'h7000);

    // Reset during flush: busy drops asynchronously and entries are gone.
    update(32'h1000, 32'h9000, 2'b11, 1'b1);
    lookup(32'h1000, 1'b1, 32'h9000, 2'b11, 2'd0);
    drain();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    check_eq("midflush_busy", 64'(busy), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("reset_busy", 64'(busy), 64'd0);
    step();
    resetn = 1'b1;
    step();
    check_eq("post_reset_busy", 64'(busy), 64'd0);
    update(32'h2000, 32'h2222, 2'b00, 1'b1);
    lookup_miss(32'h1000);
    lookup(32'h2000, 1'b1, 32'h2222, 2'b00, 2'd0);

`ifdef BTB_CONF_EN
    update(32'h6000, 32'hF000, 2'b11, 1'b1);
    lookup(32'h6000, 1'b1, 32'hF000, 2'b11, 2'd1);
    update(32'h6000, 32'h1111, 2'b00, 1'b0);
    lookup_miss(32'h6000);
    update(32'h6000, 32'hF100, 2'b01, 1'b1);
    lookup(32'h6000, 1'b1, 32'hF100, 2'b01, 2'd1);
    update(32'h7000, 32'h7777, 2'b00, 1'b0);
    lookup_miss(32'h7000);
`else
    update(32'h6000, 32'hF000, 2'b11, 1'b0);
    lookup(32'h6000, 1'b1, 32'hF000, 2'b11, 2'd1);
    update(32'h6000, 32'h1111, 2'b00, 1'b0);
    lookup(32'h6000, 1'b1, 32'h1111, 2'b00, 2'd1);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised N-way set-associative branch target buffer for the fetch stage; successor of the fixed 2-way, 64-set BTB.
- Accepts one lookup and one update per cycle.
- Returns a registered hit, target, type and way one cycle after lookup.
- Adds tree pseudo-LRU replacement, duplicate-free updates and a sequential flush engine.

Parameters:
- SETS, 64, number of sets; power of 2, 2..1024; IDX_W = log2(SETS).
- WAYS, 2, associativity; must be 1, 2 or 4.
- TAG_W, 10, stored tag width; 4..20.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  32  fetch PC.
- update_en  in  1  write a resolved branch this cycle.
- update_pc  in  32  branch PC.
- update_target  in  32  resolved target.
- update_type  in  2  00 direct, 01 call, 10 return, 11 indirect.
- update_taken  in  1  branch outcome; used only with BTB_CONF_EN.
- flush  in  1  one-cycle pulse; invalidate all entries.
- resp_valid  out  1  response valid; one cycle after lookup_valid.
- resp_hit  out  1  hit.
- resp_target  out  32  target on hit; lookup_pc+4 on miss.
- resp_type  out  2  stored type on hit; 00 on miss.
- resp_way  out  2  hitting way; 0 on miss.
- busy  out  1  flush engine active.

Behaviour:
- Reset: single clock domain; async active-low reset clears all valid bits, PLRU bits and the FSM (to IDLE). All outputs reset to 0.
- Index: pc[IDX_W+1:2].
- Tag: XOR of consecutive TAG_W-bit chunks of pc[31:IDX_W+2], starting at bit IDX_W+2; the last chunk is zero-extended.
- Entry fields: valid, tag, target[31:0], type[1:0]; plus conf[1:0] when BTB_CONF_EN is defined.
- Lookup latency: exactly 1 cycle.
  - resp_valid = registered lookup_valid.
  - resp_* fields are meaningful only when resp_valid=1; otherwise they hold their previous values.
- Hit: any valid way with a matching tag. Multiple matches cannot occur; if one did, the lowest way wins.
- PLRU state: WAYS-1 bits per set.
  - b0 = root; 0 selects the victim in the lower half.
  - WAYS=4 adds b1 (0 selects way0, else way1) and b2 (0 selects way2, else way3).
  - WAYS=1: no PLRU bits; victim is always way 0.
  - Touching way w sets the bits on its path to point away from w.
- A lookup hit touches the hit way at the end of the lookup cycle.
- Update victim selection:
  - If a valid way in the set matches the tag, overwrite that way.
  - Else, use the lowest invalid way.
  - Else, use the PLRU victim.
  - The written way is touched.
- Same cycle, same set, lookup and update:
  - The lookup reads pre-update contents (read-before-write).
  - The update's PLRU touch overrides the lookup's touch.
- Different sets: the lookup and the update proceed independently.
- FSM IDLE -> FLUSH on flush=1.
  - FLUSH clears the valid and PLRU bits of set cnt each cycle; cnt runs 0..SETS-1, then returns to IDLE.
  - busy=1 throughout FLUSH.
- During FLUSH:
  - Lookups respond with resp_hit=0 and resp_target=pc+4.
  - Updates are dropped.
  - A flush pulse restarts cnt at 0.
- Reset asserted mid-flush returns the FSM to IDLE with all entries invalid.
- The flush in-cycle is sampled only on the clk edge; a flush in the same cycle as an update drops the update.

Optional Feature:
- BTB_CONF_EN defined:
  - Each entry holds a 2-bit saturating counter.
  - A new allocation sets conf=2 when taken, else conf=1.
  - Updating an existing entry increments conf when taken, else decrements it; the target and type are rewritten only when taken.
  - A lookup hit requires conf>=2.
  - A not-taken update that finds no matching tag allocates nothing.
- BTB_CONF_EN undefined:
  - No conf storage; update_taken is ignored.
  - Every update allocates or overwrites.

Test Plan (SETS=64, WAYS=2, TAG_W=10):
1. Reset, then lookup 0x00001000 -> next cycle resp_valid=1, resp_hit=0, resp_target=0x00001004, resp_type=00.
2. Update pc 0x1000, target 0x8000, type 01, taken=1; lookup 0x1000 -> hit=1, target 0x8000, type 01, way 0.
3. Set 0 fill:
   - Update 0x1000->0xA000, then 0x2000->0xB000.
   - Lookup 0x1000 (hit, touches way 0).
   - Update 0x3000->0xC000 -> 0x2000 misses; 0x1000 and 0x3000 hit in ways 0 and 1.
4. Same cycle: update 0x4000->0xD000 and lookup 0x4000 -> that response misses; the next lookup of 0x4000 hits 0xD000. Re-update 0x4000->0xE000 -> same way reused, no duplicate.
5. With entries valid, pulse flush:
   - busy=1 for 64 cycles.
   - A mid-flush update of 0x5000 is dropped.
   - After busy=0, lookups of 0x1000 and 0x5000 miss.
   - Assert resetn=0 mid-flush -> busy=0 immediately.
6. BTB_CONF_EN defined:
   - Update 0x6000 taken -> hit.
   - Then not-taken -> lookup misses (conf=1).
   - Then taken -> hit again.
